rot_cmd_queue: RTL and testbench
================================

Name: rot_cmd_queue

Overview:
- Upstream command stage for the 32-bit rotate unit (barrel_shift_32_w_rotation_ctrl).
- Accepts signed rotate commands on a valid/ready stream and normalizes each amount into a direction bit and a 5-bit shift value.
- Buffers commands in a small FIFO and presents the head entry as direct drives for inputData/shiftVal/sel_left_or_right_rotate, qualified by a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CANON_LEFT, 0, 1 = express every command as a left rotate (out_dir always 0); 0 = sign selects direction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all queued entries
- cmd_valid  input  1  command offered
- cmd_ready  output  1  queue can accept; equals !full
- cmd_data  input  32  word to rotate
- cmd_amount  input  6  signed two's-complement amount, -32..31; positive = left, negative = right
- out_valid  output  1  head entry valid; equals !empty
- out_ready  input  1  downstream rotator consumes head
- out_data  output  32  head word, to inputData
- out_shift  output  5  head shift amount, to shiftVal
- out_dir  output  1  0 = left, 1 = right, to sel_left_or_right_rotate
- count  output  $clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count clear to 0. Resulting values: out_valid=0, cmd_ready=1, count=0. Stored data is not cleared; out_data/out_shift/out_dir are don't-care while out_valid=0.
- Normalization is combinational at push; the normalized fields are stored.
  - CANON_LEFT=0, amount >= 0: dir=0, shift=amount[4:0].
  - CANON_LEFT=0, amount < 0: dir=1, shift=(-amount) mod 32. Compute in 7 bits; -32 gives shift=0, dir=1.
  - CANON_LEFT=1: dir=0, shift=amount[4:0]. Two's-complement low bits equal the left rotate that is equivalent to the right rotate, e.g. -3 -> 29.
- Push occurs when cmd_valid && cmd_ready. Pop occurs when out_valid && out_ready.
- cmd_ready depends only on count, never on out_ready. There is no combinational ready path through the block, so a full queue stalls for one cycle even if a pop occurs that cycle.
- Latency: a push into an empty queue gives out_valid=1 on the next cycle. Head outputs are read combinationally from storage at rd_ptr.
- Simultaneous push and pop (non-full, non-empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty (count==DEPTH means full, count==0 means empty).
- Pop while empty and push while full are ignored; no state change.
- flush=1 at a clock edge clears pointers and count. It has priority over any same-cycle push or pop; a push that cycle is dropped even though cmd_ready was 1.
- Handshake rules for the upstream source: hold cmd_data/cmd_amount stable while cmd_valid && !cmd_ready.
- Handshake guarantees from this block: out_* hold stable while out_valid && !out_ready, and out_valid never drops without a pop or flush.
- Reset asserted mid-operation discards all entries immediately. Outputs return to reset values without waiting for a clock.
- Assertions (simulation only): count <= DEPTH; cmd_amount within -32..31 (always true for 6 bits).

Decomposition:
- Shared package rot_pkg:
  - ROT_W=32 and SHIFT_W=5.
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
  - Packed typedef rot_cmd_t {dir, shift[4:0], data[31:0]}, 38 bits, used for FIFO storage and shared with the rotator-side wrapper.
- One natural sub-module: rot_amount_norm, the combinational signed-amount to {dir, shift} converter carrying CANON_LEFT. It is reusable by other rotate front-ends.
- The FIFO stays inline; it is too small to justify a sub-module.

Test Plan:
- Reset, then push data=0x80000001, amount=+1 (CANON_LEFT=0) -> one cycle later out_valid=1, out_data=0x80000001, out_shift=1, out_dir=0, count=1.
- Push amount=-3, then -32 (CANON_LEFT=0) -> heads {dir=1, shift=3}, then {dir=1, shift=0}. With CANON_LEFT=1 the same inputs give {0,29} and {0,0}.
- Hold out_ready=0 and push 4 commands with DEPTH=4 -> cmd_ready=0 after the 4th and count=4. A 5th offered command is not accepted, and out_* stay stable.
- From full, out_ready=1 with cmd_valid=1 for 8 cycles -> commands pop in FIFO order across pointer wrap with no loss or duplication. The cycle after each full pop, cmd_ready re-asserts.
- With 3 entries queued, assert flush with a same-cycle push -> next cycle count=0, out_valid=0, and the pushed command is absent.
- Drop rst_n asynchronously between clock edges with 2 entries queued -> out_valid=0 and cmd_ready=1 immediately. After release, the first push appears alone at the head.

Source files
------------

// File: rtl/rot_pkg.sv
// Types and constants shared by the rotate command front-ends and the rotator-side wrapper.
package rot_pkg;

  localparam int ROT_W   = 32;
  localparam int SHIFT_W = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Normalized rotate command as held in the queue: {dir, shift, data}.
  typedef struct packed {
    logic               dir;
    logic [SHIFT_W-1:0] shift;
    logic [ROT_W-1:0]   data;
  } rot_cmd_t;

endpackage

// File: rtl/rot_amount_norm.sv
// Converts a signed 6-bit rotate amount into a direction bit and a 5-bit shift.
module rot_amount_norm
  import rot_pkg::*;
#(
  parameter int CANON_LEFT = 0
) (
  input  logic [5:0]         amount_i,
  output logic               dir_o,
  output logic [SHIFT_W-1:0] shift_o
);

  logic [SHIFT_W-1:0] mag;

  always_comb begin
    // Negate in 7 bits so -32 is handled cleanly; only the low 5 bits matter.
    mag     = SHIFT_W'(7'd0 - {amount_i[5], amount_i});
    dir_o   = DIR_LEFT;
    shift_o = amount_i[SHIFT_W-1:0];
    if ((CANON_LEFT == 0) && amount_i[5]) begin
      dir_o   = DIR_RIGHT;
      shift_o = mag;
    end
  end

endmodule

// File: rtl/rot_cmd_queue.sv
// Command FIFO in front of the 32-bit rotator: normalizes signed amounts at push and
// presents the head entry as direct rotator drives under a valid/ready handshake.
module rot_cmd_queue
  import rot_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CANON_LEFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_data,
  input  logic [5:0]               cmd_amount,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [4:0]               out_shift,
  output logic                     out_dir,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rot_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            norm_dir;
  logic [4:0]      norm_shift;
  rot_cmd_t        push_entry;
  rot_cmd_t        head;
  logic            push;
  logic            pop;

  rot_amount_norm #(
    .CANON_LEFT(CANON_LEFT)
  ) u_norm (
    .amount_i(cmd_amount),
    .dir_o   (norm_dir),
    .shift_o (norm_shift)
  );

  assign push_entry = '{dir: norm_dir, shift: norm_shift, data: cmd_data};

  // Ready depends on occupancy only, so a full queue never accepts in a pop cycle.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it maps onto plain distributed/block memory.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head.data;
  assign out_shift = head.shift;
  assign out_dir   = head.dir;
  assign count     = count_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_rot_cmd_queue.sv
// Directed bench for rot_cmd_queue: two instances (sign-directed and canonical-left) checked
// each cycle against a queue-based model, plus literal expectations at key points.
module tb_rot_cmd_queue;
  import rot_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [5:0]  cmd_amount = '0;
  logic        out_ready = 1'b0;

  logic        cmd_ready_a, out_valid_a, out_dir_a;
  logic [31:0] out_data_a;
  logic [4:0]  out_shift_a;
  logic [2:0]  count_a;
  logic        cmd_ready_b, out_valid_b, out_dir_b;
  logic [31:0] out_data_b;
  logic [4:0]  out_shift_b;
  logic [2:0]  count_b;

  int total = 0;
  int bad   = 0;
  rot_cmd_t mq_a[$];
  rot_cmd_t mq_b[$];

  always #5 clk = ~clk;

  rot_cmd_queue #(.DEPTH(DEPTH), .CANON_LEFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_data(cmd_data), .cmd_amount(cmd_amount),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_shift(out_shift_a), .out_dir(out_dir_a), .count(count_a)
  );

  rot_cmd_queue #(.DEPTH(DEPTH), .CANON_LEFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_data(cmd_data), .cmd_amount(cmd_amount),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_shift(out_shift_b), .out_dir(out_dir_b), .count(count_b)
  );

  // Rotate-amount meaning expressed with integer arithmetic.
  function automatic rot_cmd_t model_norm(logic [31:0] d, logic [5:0] amt, bit canon);
    int a;
    rot_cmd_t r;
    a = int'($signed(amt));
    r.data = d;
    if (canon) begin
      r.dir   = 1'b0;
      r.shift = 5'(((a % 32) + 32) % 32);
    end else if (a >= 0) begin
      r.dir   = 1'b0;
      r.shift = 5'(a);
    end else begin
      r.dir   = 1'b1;
      r.shift = 5'((-a) % 32);
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of normalized commands with occupancy limit DEPTH.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_a.delete();
      mq_b.delete();
    end else if (flush) begin
      mq_a.delete();
      mq_b.delete();
    end else begin
      automatic bit push_ok = cmd_valid && (mq_a.size() < DEPTH);
      automatic bit pop_ok  = out_ready && (mq_a.size() > 0);
      if (pop_ok) begin
        void'(mq_a.pop_front());
        void'(mq_b.pop_front());
      end
      if (push_ok) begin
        mq_a.push_back(model_norm(cmd_data, cmd_amount, 1'b0));
        mq_b.push_back(model_norm(cmd_data, cmd_amount, 1'b1));
      end
    end
  end

  task automatic cmp(string tag, logic ov, logic cr, logic [2:0] cnt, logic [31:0] d,
                     logic [4:0] s, logic dir, int sz, rot_cmd_t h);
    chk({tag, "_out_valid"}, 64'(ov), 64'(sz != 0));
    chk({tag, "_cmd_ready"}, 64'(cr), 64'(sz < DEPTH));
    chk({tag, "_count"}, 64'(cnt), 64'(sz));
    if (sz > 0) begin
      chk({tag, "_out_data"}, 64'(d), 64'(h.data));
      chk({tag, "_out_shift"}, 64'(s), 64'(h.shift));
      chk({tag, "_out_dir"}, 64'(dir), 64'(h.dir));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("a", out_valid_a, cmd_ready_a, count_a, out_data_a, out_shift_a, out_dir_a,
          mq_a.size(), (mq_a.size() > 0) ? mq_a[0] : '0);
      cmp("b", out_valid_b, cmd_ready_b, count_b, out_data_b, out_shift_b, out_dir_b,
          mq_b.size(), (mq_b.size() > 0) ? mq_b[0] : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bit acc;
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_a), 64'd1);
    chk("rst_count", 64'(count_a), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single push, one-cycle latency to out_valid
    cmd_valid = 1'b1; cmd_data = 32'h8000_0001; cmd_amount = 6'd1;
    tick();
    cmd_valid = 1'b0;
    chk("lat_out_valid", 64'(out_valid_a), 64'd1);
    chk("lat_out_data", 64'(out_data_a), 64'h8000_0001);
    chk("lat_out_shift", 64'(out_shift_a), 64'd1);
    chk("lat_out_dir", 64'(out_dir_a), 64'd0);
    chk("lat_count", 64'(count_a), 64'd1);

    // Negative amounts, with a simultaneous push and pop first
    out_ready = 1'b1; cmd_valid = 1'b1; cmd_data = 32'hA5A5_A5A5; cmd_amount = 6'h3D; // -3
    tick();
    out_ready = 1'b0; cmd_data = 32'h1234_5678; cmd_amount = 6'h20;                    // -32
    tick();
    cmd_valid = 1'b0;
    chk("neg3_dir_a", 64'(out_dir_a), 64'd1);
    chk("neg3_shift_a", 64'(out_shift_a), 64'd3);
    chk("neg3_dir_b", 64'(out_dir_b), 64'd0);
    chk("neg3_shift_b", 64'(out_shift_b), 64'd29);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("neg32_dir_a", 64'(out_dir_a), 64'd1);
    chk("neg32_shift_a", 64'(out_shift_a), 64'd0);
    chk("neg32_dir_b", 64'(out_dir_b), 64'd0);
    chk("neg32_shift_b", 64'(out_shift_b), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_count", 64'(count_a), 64'd0);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_data = 32'hF00D_0000 + 32'(i);
      cmd_amount = (i == 0) ? 6'd5 : (i == 1) ? 6'h39 : (i == 2) ? 6'd31 : 6'h3F;
      tick();
    end
    chk("full_cmd_ready", 64'(cmd_ready_a), 64'd0);
    chk("full_count", 64'(count_a), 64'd4);
    k = 0;
    cmd_data = 32'hC000_0000; cmd_amount = 6'h33;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_count", 64'(count_a), 64'd4);
      chk("stall_out_data", 64'(out_data_a), 64'hF00D_0000);
    end

    // Stream through from full across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = cmd_ready_a;
      tick();
      if (i == 0) begin
        chk("refill_count", 64'(count_a), 64'd3);
        chk("refill_cmd_ready", 64'(cmd_ready_a), 64'd1);
      end
      if (acc) begin
        k++;
        cmd_data = 32'hC000_0000 + 32'(k);
        cmd_amount = 6'(k * 5 - 13);
      end
    end
    cmd_valid = 1'b0;
    chk("stream_count", 64'(count_a), 64'd3);
    chk("stream_pushed", 64'(k), 64'd7);
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    chk("stream_empty", 64'(out_valid_a), 64'd0);

    // Flush wins over a same-cycle push
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_data = 32'hAB00_0000 + 32'(i); cmd_amount = 6'(i);
      tick();
    end
    flush = 1'b1; cmd_data = 32'hDEAD_0001;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("flush_count", 64'(count_a), 64'd0);
    chk("flush_out_valid", 64'(out_valid_a), 64'd0);
    cmd_valid = 1'b1; cmd_data = 32'h0BAD_F00D; cmd_amount = 6'd2;
    tick();
    cmd_valid = 1'b0;
    chk("postflush_data", 64'(out_data_a), 64'h0BAD_F00D);
    chk("postflush_count", 64'(count_a), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_data = 32'h7700_0000 + 32'(i); cmd_amount = 6'(i + 1);
      tick();
    end
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_a), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready_a), 64'd1);
    chk("arst_count", 64'(count_b), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_data = 32'h5A5A_0003; cmd_amount = 6'h3B; // -5
    tick();
    cmd_valid = 1'b0;
    chk("after_rst_data", 64'(out_data_a), 64'h5A5A_0003);
    chk("after_rst_count", 64'(count_a), 64'd1);
    chk("after_rst_shift_a", 64'(out_shift_a), 64'd5);
    chk("after_rst_dir_a", 64'(out_dir_a), 64'd1);
    chk("after_rst_shift_b", 64'(out_shift_b), 64'd27);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
